// File: rtl/vproc_mem_arb_model.sv
// -----------------------------------------------------------------------------
// vproc_mem_arb_model
//   Multi-port memory model for Vicuna simulation benches. PORTS requesters
//   share one word-addressed array through a round-robin arbiter with a
//   combinational grant. Each granted access (read or write) returns one
//   response exactly LATENCY cycles later through a fully pipelined response
//   path. Addresses beyond MEM_SZ report an error and never modify the array.
//
//   Optional feature macro: MEM_STALL_EN
//     When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every
//     cycle and suppresses all grants while lfsr[1:0] == 2'b00.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous reset, active low
//   req_i       per-port request (held until granted)
//   gnt_o       per-port grant, one-hot or zero, combinational
//   addr_i      per-port byte address
//   we_i        per-port write enable
//   be_i        per-port byte enables
//   wdata_i     per-port write data
//   rvalid_o    per-port response valid
//   err_o       per-port response error (qualified by rvalid_o)
//   rdata_o     per-port read data (qualified by rvalid_o; old word for writes)
//   prog_end_o  one-cycle pulse after a granted non-error read of END_ADDR
// -----------------------------------------------------------------------------
module vproc_mem_arb_model #(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned MEM_W      = 32,
  parameter int unsigned MEM_SZ     = 262144,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] END_ADDR   = 32'h0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [PORTS-1:0]                req_i,
  output logic [PORTS-1:0]                gnt_o,
  input  logic [PORTS-1:0][31:0]          addr_i,
  input  logic [PORTS-1:0]                we_i,
  input  logic [PORTS-1:0][MEM_W/8-1:0]   be_i,
  input  logic [PORTS-1:0][MEM_W-1:0]     wdata_i,
  output logic [PORTS-1:0]                rvalid_o,
  output logic [PORTS-1:0]                err_o,
  output logic [PORTS-1:0][MEM_W-1:0]     rdata_o,
  output logic                            prog_end_o
);

  localparam int unsigned BYTES = MEM_W / 8;
  localparam int unsigned AW    = $clog2(MEM_SZ);
  localparam int unsigned OFF   = $clog2(BYTES);
  localparam int unsigned IDX_W = AW - OFF;
  localparam int unsigned DEPTH = MEM_SZ / BYTES;
  localparam int unsigned PW    = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef struct packed {
    logic             valid;
    logic [PW-1:0]    port;
    logic             err;
    logic [MEM_W-1:0] data;
  } resp_t;

  logic [PW-1:0]    rr_q, rr_d;
  logic             stall;
  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;

  logic [31:0]      g_addr;
  logic             g_we;
  logic [BYTES-1:0] g_be;
  logic [MEM_W-1:0] g_wdata;
  logic             g_err;
  logic [IDX_W-1:0] g_index;
  logic [MEM_W-1:0] rd_word;

  logic [MEM_W-1:0] mem_q [DEPTH];
  resp_t            pipe_q [LATENCY];
  resp_t            out_resp;
  logic             prog_end_q;

  // ---------------------------------------------------------------------------
  // Grant suppression source
  // ---------------------------------------------------------------------------
`ifdef MEM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= STALL_SEED;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_q, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    gnt_o   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(PORTS); k++) begin
      cand = PW'((int'(rr_q) + k) % int'(PORTS));
      if (!gnt_any && req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (stall) gnt_any = 1'b0;
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) rr_d = (int'(gnt_idx) == int'(PORTS) - 1) ? '0 : gnt_idx + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Granted access decode
  // ---------------------------------------------------------------------------
  assign g_addr  = addr_i[gnt_idx];
  assign g_we    = we_i[gnt_idx];
  assign g_be    = be_i[gnt_idx];
  assign g_wdata = wdata_i[gnt_idx];
  assign g_err   = |g_addr[31:AW];
  assign g_index = g_addr[AW-1:OFF];
  // Sampled before the write commits, so a write returns the previous word.
  assign rd_word = g_err ? '0 : mem_q[g_index];

  // NOTE: the storage array is deliberately left without a reset: contents
  // survive rst_ni like a real memory, and only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (gnt_any && g_we && !g_err) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (g_be[b]) mem_q[g_index][8*b +: 8] <= g_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline, pointer and program-end pulse
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours (the pipeline shifts rather
  // than collapsing into one stage).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(LATENCY); s++) pipe_q[s] <= '0;
      rr_q       <= '0;
      prog_end_q <= 1'b0;
    end else begin
      pipe_q[0] <= '{valid: gnt_any, port: gnt_idx, err: g_err, data: rd_word};
      for (int s = 1; s < int'(LATENCY); s++) pipe_q[s] <= pipe_q[s-1];
      rr_q       <= rr_d;
      prog_end_q <= gnt_any && !g_we && !g_err && (g_addr == END_ADDR);
    end
  end

  assign out_resp   = pipe_q[LATENCY-1];
  assign prog_end_o = prog_end_q;

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (out_resp.valid) begin
      rvalid_o[out_resp.port] = 1'b1;
      err_o[out_resp.port]    = out_resp.err;
      rdata_o[out_resp.port]  = out_resp.data;
    end
  end

endmodule

// File: tb/tb_vproc_mem_arb_model.sv
// -----------------------------------------------------------------------------
// tb_vproc_mem_arb_model
//   Directed and randomized checks of vproc_mem_arb_model (PORTS=2,
//   LATENCY=4, END_ADDR=0x200) against a transaction-level reference model:
//   pending requests per port, a word map for memory contents and a queue of
//   expected responses keyed by due cycle.
// -----------------------------------------------------------------------------
module tb_vproc_mem_arb_model;

  localparam int          PORTS = 2;
  localparam int          LAT   = 4;
  localparam logic [31:0] END_A = 32'h0000_0200;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [PORTS-1:0]         req;
  logic [PORTS-1:0]         gnt;
  logic [PORTS-1:0][31:0]   addr;
  logic [PORTS-1:0]         we;
  logic [PORTS-1:0][3:0]    be;
  logic [PORTS-1:0][31:0]   wdata;
  logic [PORTS-1:0]         rvalid;
  logic [PORTS-1:0]         err;
  logic [PORTS-1:0][31:0]   rdata;
  logic                     prog_end;

  vproc_mem_arb_model #(
    .PORTS(PORTS), .MEM_W(32), .MEM_SZ(262144), .LATENCY(LAT),
    .END_ADDR(END_A), .STALL_SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .err_o(err),
    .rdata_o(rdata), .prog_end_o(prog_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          act;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    int          port;
    bit          err;
    bit          known;
    logic [31:0] data;
  } exp_t;

  req_t        pend [PORTS];
  exp_t        expq [$];
  logic [31:0] mdl  [int];
  int          cyc = 0, rr = 0, pe_due = -1;
  int          total = 0, bad = 0;
  logic [15:0] lfsr = SEED;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < PORTS; p++) begin
      req[p]   = pend[p].act;
      we[p]    = pend[p].we;
      addr[p]  = pend[p].addr;
      be[p]    = pend[p].be;
      wdata[p] = pend[p].wdata;
    end
  endtask

  task automatic issue(int p, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    pend[p] = '{act: 1'b1, we: w, addr: a, be: b, wdata: d};
    apply();
  endtask

  // One clock cycle: compare grant and responses mid-cycle, then advance model.
  task automatic cycle();
    int          g;
    bit          stall;
    bit          have;
    bit          e;
    int          key;
    logic [31:0] old, nw;
    logic [31:0] ev;
    exp_t        hit;
    req_t        r;
    @(negedge clk);
    stall = 1'b0;
`ifdef MEM_STALL_EN
    stall = (lfsr[1:0] == 2'b00);
`endif
    g = -1;
    if (!stall)
      for (int k = 0; k < PORTS; k++)
        if (g < 0 && pend[(rr + k) % PORTS].act) g = (rr + k) % PORTS;
    ev = '0;
    if (g >= 0) ev[g] = 1'b1;
    check("gnt", {30'b0, gnt}, ev);

    have = 1'b0;
    hit  = '{due: 0, port: 0, err: 1'b0, known: 1'b0, data: '0};
    while (expq.size() > 0 && expq[0].due == cyc) begin
      hit  = expq.pop_front();
      have = 1'b1;
    end
    ev = '0;
    if (have) ev[hit.port] = 1'b1;
    check("rvalid", {30'b0, rvalid}, ev);
    if (have) begin
      check("err", {31'b0, err[hit.port]}, {31'b0, hit.err});
      if (hit.known) check("rdata", rdata[hit.port], hit.data);
    end
    check("prog_end", {31'b0, prog_end}, {31'b0, pe_due == cyc});

    if (g >= 0) begin
      r   = pend[g];
      e   = (r.addr[31:18] != 14'd0);
      key = int'(r.addr[17:2]);
      old = '0;
      if (!e && mdl.exists(key)) old = mdl[key];
      expq.push_back('{due: cyc + LAT, port: g, err: e, known: e || mdl.exists(key), data: old});
      if (r.we && !e) begin
        nw = old;
        for (int b = 0; b < 4; b++) if (r.be[b]) nw[8*b +: 8] = r.wdata[8*b +: 8];
        mdl[key] = nw;
      end
      if (!r.we && !e && r.addr == END_A) pe_due = cyc + 1;
      rr = (g + 1) % PORTS;
      pend[g].act = 1'b0;
    end

    @(posedge clk);
`ifdef MEM_STALL_EN
    if (rst_n) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
    #1;
    cyc++;
    apply();
  endtask

  task automatic wait_idle();
    int busy;
    busy = 1;
    for (int n = 0; n < 100 && busy != 0; n++) begin
      cycle();
      busy = 0;
      for (int p = 0; p < PORTS; p++) if (pend[p].act) busy = 1;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    wait_idle();
    for (int n = 0; n < LAT + 2; n++) cycle();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    for (int p = 0; p < PORTS; p++) pend[p].act = 1'b0;
    apply();
    expq.delete();
    pe_due = -1;
    rr     = 0;
    lfsr   = SEED;
    #1;
    check("rst_rvalid", {30'b0, rvalid}, 32'd0);
    check("rst_err", {30'b0, err}, 32'd0);
    check("rst_rdata0", rdata[0], 32'd0);
    check("rst_rdata1", rdata[1], 32'd0);
    check("rst_prog_end", {31'b0, prog_end}, 32'd0);
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int          s;
    logic [31:0] a;
    s = $urandom_range(0, 21);
    if (s < 16)       a = 32'h100 + 32'(4 * s);
    else if (s == 16) a = END_A;
    else if (s < 20)  a = 32'(4 * (s - 17));
    else              a = $urandom() | 32'h0004_0000;
    if (s < 20 && $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    for (int p = 0; p < PORTS; p++) pend[p] = '{act: 1'b0, we: 1'b0, addr: '0, be: '0, wdata: '0};
    apply();
    do_reset(2);

    // Preload every word the random phase can touch.
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hFFFF_FFFF);
      issue(1, 1'b1, 32'(4 * (i % 3)), 4'hF, $urandom());
      wait_idle();
    end
    issue(0, 1'b1, END_A, 4'hF, 32'h0BAD_F00D);
    wait_idle();
    drain();

    // Full-word write then readback.
    issue(0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    wait_idle();
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    drain();

    // Back-to-back reads on one port.
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0); wait_idle();
    issue(0, 1'b0, 32'h4, 4'h0, 32'h0); wait_idle();
    issue(0, 1'b0, 32'h8, 4'h0, 32'h0);
    drain();

    // Partial byte write over all-ones, with a competing read of the same word.
    issue(0, 1'b1, 32'h104, 4'b0101, 32'h1122_3344);
    issue(1, 1'b0, 32'h104, 4'h0, 32'h0);
    wait_idle();
    issue(1, 1'b0, 32'h104, 4'h0, 32'h0);
    drain();

    // Out-of-range accesses: error response, aliasing word untouched.
    issue(1, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
    issue(0, 1'b1, 32'h0004_0100, 4'hF, 32'h1234_5678);
    wait_idle();
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    drain();

    // Program-end pulse: only a non-error read of exactly END_ADDR.
    issue(0, 1'b0, END_A, 4'h0, 32'h0);
    issue(1, 1'b1, END_A, 4'hF, 32'h0BAD_F00D);
    wait_idle();
    issue(1, 1'b0, END_A | 32'h0004_0000, 4'h0, 32'h0);
    drain();

    // Randomized traffic; busy stretches keep both ports requesting.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < PORTS; p++)
        if (!pend[p].act && (n < 40 || $urandom_range(0, 3) != 0))
          issue(p, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom()), $urandom());
      cycle();
    end
    drain();

    // Reset with three accesses in flight: none of them may respond.
    issue(0, 1'b0, 32'h108, 4'h0, 32'h0); cycle();
    issue(1, 1'b0, 32'h10C, 4'h0, 32'h0); cycle();
    issue(0, 1'b0, 32'h110, 4'h0, 32'h0); cycle();
    do_reset(2);
    for (int n = 0; n < LAT + 4; n++) cycle();

    // Array contents survive reset.
    issue(1, 1'b0, 32'h104, 4'h0, 32'h0);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
